psg_write_encoder: RTL and testbench

PSG_WRITE_ENCODER -- requirements
Module: psg_write_encoder

---
 rtl/psg_write_encoder.sv | 164 ++++++++++++++++
 tb/tb_psg_write_encoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/psg_write_encoder.sv
// psg_write_encoder: turns tone / attenuation / noise commands into the
// byte stream of an SN76489-style PSG register-write port. Each byte is
// held for HOLD_CYCLES clocks, except the noise control byte, which lasts
// exactly one clock so the noise generator restarts only once.
//
// Optional feature: define PSG_ENC_SHORT_WRITE_EN to keep a per-channel
// shadow of the last tone high bits. A tone command whose value[9:4]
// matches a valid shadow entry then emits only the latch byte.
//
// Handshake: a command is accepted on every rising edge where cmd_valid
// and cmd_ready are both high; the command inputs are sampled only then.
// cmd_ready is high in IDLE and in the last cycle of a sequence's final
// byte, so back-to-back commands form a gap-free byte stream.
module psg_write_encoder #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [1:0] cmd_chan,
  input  logic [9:0] cmd_value,
  output logic [7:0] bus_data,
  output logic       busy,
  output logic       cmd_error,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LATCH     = 2'd1;
  localparam logic [1:0] ST_DATA      = 2'd2;
  localparam logic [1:0] ST_NOISE_CLR = 2'd3;

  localparam logic [1:0] TYPE_TONE  = 2'd0;
  localparam logic [1:0] TYPE_ATTEN = 2'd1;
  localparam logic [1:0] TYPE_NOISE = 2'd2;

  localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] next_after;   // state that follows the first byte; IDLE = single-byte sequence
  logic [3:0] hold_cnt;
  logic [7:0] data_byte;    // pending tone data byte
  logic [7:0] bus_q;
  logic       err_q;

  logic       accept;
  logic       cmd_illegal;
  logic       final_byte;
  logic       short_hit;
  logic [7:0] first_byte;
  logic [3:0] first_hold;
  logic [1:0] first_after;

`ifdef PSG_ENC_SHORT_WRITE_EN
  logic [5:0] shadow_hi  [4];
  logic [3:0] shadow_vld;
  logic [1:0] tone_chan;
`endif

  // Decode the presented command into its first byte and follow-on state.
  always_comb begin
    cmd_illegal = (cmd_type == 2'd3) || ((cmd_type == TYPE_TONE) && (cmd_chan == 2'd3));
`ifdef PSG_ENC_SHORT_WRITE_EN
    short_hit = shadow_vld[cmd_chan] && (shadow_hi[cmd_chan] == cmd_value[9:4]);
`else
    short_hit = 1'b0;
`endif
    first_byte  = bus_q;
    first_hold  = HOLD_RELOAD;
    first_after = ST_IDLE;
    case (cmd_type)
      TYPE_TONE: begin
        first_byte  = {1'b1, cmd_chan, 1'b0, cmd_value[3:0]};
        first_after = short_hit ? ST_IDLE : ST_DATA;
      end
      TYPE_ATTEN: begin
        first_byte  = {1'b1, cmd_chan, 1'b1, cmd_value[3:0]};
      end
      TYPE_NOISE: begin
        first_byte  = {5'b11100, cmd_value[2:0]};
        first_hold  = 4'd0;
        first_after = ST_NOISE_CLR;
      end
      default: ;
    endcase
  end

  // Ready in IDLE or in the last hold cycle of a sequence's final byte.
  always_comb begin
    final_byte = ((state == ST_LATCH) && (next_after == ST_IDLE)) ||
                 (state == ST_DATA) || (state == ST_NOISE_CLR);
    cmd_ready  = !reset && ((state == ST_IDLE) || (final_byte && (hold_cnt == 4'd0)));
    accept     = cmd_valid && cmd_ready;
  end

  // Sequencer: start commands, count hold cycles, step through bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      next_after <= ST_IDLE;
      hold_cnt   <= 4'd0;
      data_byte  <= 8'h00;
      bus_q      <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        if (cmd_illegal) begin
          err_q    <= 1'b1;
          state    <= ST_IDLE;
          hold_cnt <= 4'd0;
        end else begin
          state      <= ST_LATCH;
          bus_q      <= first_byte;
          hold_cnt   <= first_hold;
          next_after <= first_after;
          data_byte  <= {2'b00, cmd_value[9:4]};
        end
      end else if (state != ST_IDLE) begin
        if (hold_cnt != 4'd0) begin
          hold_cnt <= hold_cnt - 4'd1;
        end else begin
          case (state)
            ST_LATCH: begin
              state    <= next_after;
              hold_cnt <= HOLD_RELOAD;
              if (next_after == ST_DATA) bus_q <= data_byte;
              else if (next_after == ST_NOISE_CLR) bus_q <= 8'h00;
            end
            default: begin
              state    <= ST_IDLE;
              hold_cnt <= 4'd0;
            end
          endcase
        end
      end
    end
  end

`ifdef PSG_ENC_SHORT_WRITE_EN
  // Shadow of tone high bits, written as the data byte goes onto the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_vld <= 4'b0000;
      tone_chan  <= 2'd0;
      for (int i = 0; i < 4; i++) shadow_hi[i] <= 6'd0;
    end else begin
      if (accept && !cmd_illegal && (cmd_type == TYPE_TONE)) tone_chan <= cmd_chan;
      if (!accept && (state == ST_LATCH) && (hold_cnt == 4'd0) && (next_after == ST_DATA)) begin
        shadow_hi[tone_chan]  <= data_byte[5:0];
        shadow_vld[tone_chan] <= 1'b1;
      end
    end
  end
`endif

  assign bus_data  = bus_q;
  assign busy      = (state != ST_IDLE);
  assign cmd_error = err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_psg_write_encoder.sv
// Directed bench for psg_write_encoder: one instance with HOLD_CYCLES=1
// and one with HOLD_CYCLES=3 share command fields and reset, each with its
// own cmd_valid. Expected bytes are hand-encoded PSG register writes.
module tb_psg_write_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] cmd_type;
  logic [1:0] cmd_chan;
  logic [9:0] cmd_value;

  logic       v1, r1, busy1, err1;
  logic [7:0] bus1;
  logic [1:0] st1;
  logic       v3, r3, busy3, err3;
  logic [7:0] bus3;
  logic [1:0] st3;

  int n_cmp = 0;
  int n_bad = 0;

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  psg_write_encoder #(.HOLD_CYCLES(1)) u_h1 (
    .clk(clk), .reset(reset), .cmd_valid(v1), .cmd_ready(r1),
    .cmd_type(cmd_type), .cmd_chan(cmd_chan), .cmd_value(cmd_value),
    .bus_data(bus1), .busy(busy1), .cmd_error(err1), .state_dbg(st1)
  );

  psg_write_encoder #(.HOLD_CYCLES(3)) u_h3 (
    .clk(clk), .reset(reset), .cmd_valid(v3), .cmd_ready(r3),
    .cmd_type(cmd_type), .cmd_chan(cmd_chan), .cmd_value(cmd_value),
    .bus_data(bus3), .busy(busy3), .cmd_error(err3), .state_dbg(st3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [1:0] t, input logic [1:0] c, input logic [9:0] v);
    cmd_type  = t;
    cmd_chan  = c;
    cmd_value = v;
  endtask

  initial begin
    reset = 1'b1; v1 = 1'b0; v3 = 1'b0;
    set_cmd(2'd0, 2'd0, 10'd0);
    tick(); tick(); tick();
    check_eq("rst_bus1", bus1, 8'h00);
    check_eq("rst_bus3", bus3, 8'h00);
    check_eq("rst_ready1", r1, 1'b0);
    check_eq("rst_busy3", busy3, 1'b0);
    check_eq("rst_err1", err1, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("ready_after_rst1", r1, 1'b1);
    check_eq("ready_after_rst3", r3, 1'b1);

    // Tone ch1 0x2A5, HOLD=1.
    set_cmd(2'd0, 2'd1, 10'h2A5); v1 = 1'b1;
    tick(); v1 = 1'b0;
    check_eq("tone_latch", bus1, 8'hA5);
    check_eq("tone_latch_busy", busy1, 1'b1);
    check_eq("tone_latch_ready", r1, 1'b0);
    tick();
    check_eq("tone_data", bus1, 8'h2A);
    check_eq("tone_data_ready", r1, 1'b1);
    tick();
    check_eq("tone_held", bus1, 8'h2A);
    check_eq("tone_idle_busy", busy1, 1'b0);

    // Attenuation ch3 0x7, HOLD=3.
    set_cmd(2'd1, 2'd3, 10'h007); v3 = 1'b1;
    tick(); v3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("att_bus_%0d", i), bus3, 8'hF7);
      check_eq($sformatf("att_busy_%0d", i), busy3, 1'b1);
      check_eq($sformatf("att_ready_%0d", i), r3, (i == 2) ? 1'b1 : 1'b0);
      tick();
    end
    check_eq("att_held", bus3, 8'hF7);
    check_eq("att_done_busy", busy3, 1'b0);

    // Noise 0x5, HOLD=3: one-cycle control byte, then three 0x00 cycles.
    set_cmd(2'd2, 2'd1, 10'h005); v3 = 1'b1;
    tick(); v3 = 1'b0;
    check_eq("noise_byte", bus3, 8'hE5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("noise_clr_%0d", i), bus3, 8'h00);
      check_eq($sformatf("noise_clr_busy_%0d", i), busy3, 1'b1);
    end
    tick();
    check_eq("noise_held", bus3, 8'h00);
    check_eq("noise_done_busy", busy3, 1'b0);

    // Illegal commands: tone ch3 on HOLD=1, reserved type on HOLD=3.
    set_cmd(2'd0, 2'd3, 10'h3FF); v1 = 1'b1;
    tick(); v1 = 1'b0;
    check_eq("ill_tone_err", err1, 1'b1);
    check_eq("ill_tone_bus", bus1, 8'h2A);
    check_eq("ill_tone_ready", r1, 1'b1);
    check_eq("ill_tone_busy", busy1, 1'b0);
    tick();
    check_eq("ill_tone_err_end", err1, 1'b0);
    set_cmd(2'd3, 2'd0, 10'h0FF); v3 = 1'b1;
    tick(); v3 = 1'b0;
    check_eq("ill_type_err", err3, 1'b1);
    check_eq("ill_type_bus", bus3, 8'h00);
    tick();
    check_eq("ill_type_err_end", err3, 1'b0);

    // Back-to-back tone ch0: 0x123 then 0x12F, HOLD=1.
    set_cmd(2'd0, 2'd0, 10'h123); v1 = 1'b1;
    tick();
    set_cmd(2'd0, 2'd0, 10'h12F);
    check_eq("b2b_latch0", bus1, 8'h83);
    check_eq("b2b_ready0", r1, 1'b0);
    tick();
    check_eq("b2b_data0", bus1, 8'h12);
    check_eq("b2b_ready1", r1, 1'b1);
    tick(); v1 = 1'b0;
    check_eq("b2b_latch1", bus1, 8'h8F);
`ifdef PSG_ENC_SHORT_WRITE_EN
    check_eq("b2b_short_ready", r1, 1'b1);
    tick();
    check_eq("b2b_short_held", bus1, 8'h8F);
    check_eq("b2b_short_busy", busy1, 1'b0);
`else
    check_eq("b2b_full_ready", r1, 1'b0);
    tick();
    check_eq("b2b_data1", bus1, 8'h12);
    tick();
    check_eq("b2b_held", bus1, 8'h12);
    check_eq("b2b_busy", busy1, 1'b0);
`endif

    // Reset during the data byte of tone ch2 0x155, then a fresh command.
    set_cmd(2'd0, 2'd2, 10'h155); v1 = 1'b1;
    tick(); v1 = 1'b0;
    check_eq("abort_latch", bus1, 8'hC5);
    tick();
    check_eq("abort_data", bus1, 8'h15);
    reset = 1'b1;
    tick();
    check_eq("abort_bus", bus1, 8'h00);
    check_eq("abort_busy", busy1, 1'b0);
    check_eq("abort_ready", r1, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("abort_ready_after", r1, 1'b1);
    set_cmd(2'd1, 2'd0, 10'h00A); v1 = 1'b1;
    tick(); v1 = 1'b0;
    check_eq("abort_new_cmd", bus1, 8'h9A);
    tick();
    check_eq("abort_new_held", bus1, 8'h9A);
    check_eq("abort_new_busy", busy1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
